// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmit/receive blocks.
// Frame timing helpers live here so that the TX and a future RX agree on them.
package i2s_pkg;

  localparam int I2S_DEFAULT_WIDTH    = 16;
  localparam int I2S_DEFAULT_BCLK_DIV = 4;
  localparam int I2S_FRAME_SLOTS      = 2 * I2S_DEFAULT_WIDTH;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

  // System clocks in one stereo frame: 2*width slots of 2*bclk_div clocks each.
  function automatic int i2s_frame_clks(input int width, input int bclk_div);
    return 4 * width * bclk_div;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV system clocks and flags the
// clock on which bclk goes 1->0, so downstream logic updates with it.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = I2S_DEFAULT_BCLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic o_bclk,
  output logic o_fall_tick
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV - 1);

  logic [CW-1:0] r_div_cnt;
  logic          r_bclk;
  logic          w_wrap;

  assign w_wrap = (r_div_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  // Combinational so the top's registers change on the same edge that drops bclk.
  assign o_fall_tick = w_wrap & r_bclk;
  assign o_bclk      = r_bclk;

endmodule

// File: rtl/i2s_sample_tx.sv
// I2S transmitter: holds one stereo pair behind a valid/ready handshake and
// shifts each frame out MSB-first with the standard one-bit data delay.
module i2s_sample_tx
  import i2s_pkg::*;
#(
  parameter int WIDTH    = I2S_DEFAULT_WIDTH,
  parameter int BCLK_DIV = I2S_DEFAULT_BCLK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
);

  localparam int SLOTS = 2 * WIDTH;
  localparam int SW    = $clog2(SLOTS);
  localparam logic [SW-1:0] LAST_SLOT  = SW'(SLOTS - 1);
  localparam logic [SW-1:0] RIGHT_SLOT = SW'(WIDTH);

  logic             w_fall_tick;
  logic             w_frame_start;
  logic             w_accept;
  logic             w_load;
  logic [SW-1:0]    w_slot_next;
  logic [SLOTS-1:0] w_frame_word;

  logic             r_full;
  logic [WIDTH-1:0] r_left_h;
  logic [WIDTH-1:0] r_right_h;
  logic [SW-1:0]    r_slot;
  i2s_chan_e        r_lrclk;
  logic [SLOTS-1:0] r_shift;
  logic             r_delay;
  logic             r_sdata;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk         (clk),
    .reset       (reset),
    .o_bclk      (bclk),
    .o_fall_tick (w_fall_tick)
  );

  // Accept needs an empty holding register and load needs a full one, so the
  // two can never coincide; an accept on an empty load tick waits a frame.
  assign w_accept      = in_valid && !r_full;
  assign w_frame_start = w_fall_tick && (r_slot == LAST_SLOT);
  assign w_load        = w_frame_start && r_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full    <= 1'b0;
      r_left_h  <= '0;
      r_right_h <= '0;
    end else if (w_accept) begin
      r_full    <= 1'b1;
      r_left_h  <= left;
      r_right_h <= right;
    end else if (w_load) begin
      r_full    <= 1'b0;
    end
  end

  always_comb begin
    w_slot_next  = (r_slot == LAST_SLOT) ? '0 : r_slot + SW'(1);
    w_frame_word = r_full ? {r_left_h, r_right_h} : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot  <= LAST_SLOT;
      r_lrclk <= CH_LEFT;
    end else if (w_fall_tick) begin
      r_slot  <= w_slot_next;
      r_lrclk <= (w_slot_next >= RIGHT_SLOT) ? CH_RIGHT : CH_LEFT;
    end
  end

  // The delay flop gives the one-bit lag: slot 0 still carries the previous
  // frame's right LSB while the new left MSB waits in r_delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_delay <= 1'b0;
      r_sdata <= 1'b0;
    end else if (w_fall_tick) begin
      r_sdata <= r_delay;
      if (w_frame_start) begin
        r_delay <= w_frame_word[SLOTS-1];
        r_shift <= {w_frame_word[SLOTS-2:0], 1'b0};
      end else begin
        r_delay <= r_shift[SLOTS-1];
        r_shift <= {r_shift[SLOTS-2:0], 1'b0};
      end
    end
  end

  assign in_ready = !r_full;
  assign lrclk    = (r_lrclk == CH_RIGHT);
  assign sdata    = r_sdata;
  assign underrun = w_frame_start && !r_full;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: a time-indexed reference model predicts every
// output each clock from the elapsed clock count and the pairs accepted.
module tb_i2s_sample_tx;
  import i2s_pkg::*;

  localparam int W     = 16;
  localparam int DIV   = 2;
  localparam int SLOTS = 2 * W;
  localparam int FRAME = i2s_frame_clks(W, DIV);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] left = '0;
  logic [W-1:0] right = '0;
  logic         bclk;
  logic         lrclk;
  logic         sdata;
  logic         underrun;

  int assertCount = 0;
  int failCount   = 0;

  int           t;
  int           acceptCount;
  bit           mFull;
  logic [2*W-1:0] mHeld;
  logic [2*W-1:0] curStream;
  logic [2*W-1:0] prevStream;

  always #5 clk = ~clk;

  i2s_sample_tx #(
    .WIDTH    (W),
    .BCLK_DIV (DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .left     (left),
    .right    (right),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  // A frame begins on the fall tick that enters slot 0 (ticks at multiples of 2*DIV).
  function automatic bit isFrameStart(input int tt);
    if (tt <= 0) return 1'b0;
    return ((tt % (2 * DIV)) == 0) && ((((tt / (2 * DIV)) - 1) % SLOTS) == 0);
  endfunction

  function automatic int curSlot();
    int m;
    m = t / (2 * DIV);
    if (m == 0) return -1;
    return (m - 1) % SLOTS;
  endfunction

  task automatic resetModel();
    t          = 0;
    acceptCount = 0;
    mFull      = 1'b0;
    mHeld      = '0;
    curStream  = '0;
    prevStream = '0;
  endtask

  task automatic modelEdge();
    int tn;
    bit acc;
    tn  = t + 1;
    acc = in_valid && !mFull;
    if (isFrameStart(tn)) begin
      prevStream = curStream;
      curStream  = mFull ? mHeld : '0;
      mFull      = 1'b0;
    end
    if (acc) begin
      mHeld = {left, right};
      mFull = 1'b1;
      acceptCount++;
    end
    t = tn;
  endtask

  task automatic checkOutput();
    logic expBclk, expLr, expSd, expRdy, expUnd;
    int n;
    expBclk = ((t / DIV) % 2) == 1;
    n = curSlot();
    if (n < 0) begin
      expLr = 1'b0;
      expSd = 1'b0;
    end else begin
      expLr = (n >= W);
      expSd = (n == 0) ? prevStream[0] : curStream[2*W-n];
    end
    expRdy = !mFull;
    expUnd = !reset && isFrameStart(t + 1) && !mFull;

    assertCount++;
    assert (bclk === expBclk) else begin
      failCount++;
      $error("[TB] FAIL bclk: observed %b expected %b (t=%0d)", bclk, expBclk, t);
    end
    assertCount++;
    assert (lrclk === expLr) else begin
      failCount++;
      $error("[TB] FAIL lrclk: observed %b expected %b (t=%0d slot=%0d)", lrclk, expLr, t, n);
    end
    assertCount++;
    assert (sdata === expSd) else begin
      failCount++;
      $error("[TB] FAIL sdata: observed %b expected %b (t=%0d slot=%0d)", sdata, expSd, t, n);
    end
    assertCount++;
    assert (in_ready === expRdy) else begin
      failCount++;
      $error("[TB] FAIL in_ready: observed %b expected %b (t=%0d)", in_ready, expRdy, t);
    end
    assertCount++;
    assert (underrun === expUnd) else begin
      failCount++;
      $error("[TB] FAIL underrun: observed %b expected %b (t=%0d)", underrun, expUnd, t);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] l, input logic [W-1:0] r);
    in_valid = v;
    left     = l;
    right    = r;
  endtask

  task automatic stepClock();
    @(posedge clk);
    if (!reset) modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  // Idle cycles scramble the data lines so stray sampling would show up.
  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b0, W'($urandom), W'($urandom));
      stepClock();
    end
  endtask

  task automatic offerUntilAccepted(input logic [W-1:0] l, input logic [W-1:0] r,
                                    input int bound, input string tag);
    int startCount;
    int k;
    bit got;
    startCount = acceptCount;
    applyStimulus(1'b1, l, r);
    k = 0;
    while ((acceptCount == startCount) && (k < bound)) begin
      stepClock();
      k++;
    end
    got = (acceptCount != startCount);
    assertCount++;
    assert (got === 1'b1) else begin
      failCount++;
      $error("[TB] FAIL %s: no accept within %0d clks (observed 0 accepts, expected 1)", tag, bound);
    end
  endtask

  task automatic waitSlot(input int s, input int bound, input string tag);
    int k;
    bit reached;
    k = 0;
    while ((curSlot() != s) && (k < bound)) begin
      idle(1);
      k++;
    end
    reached = (curSlot() == s);
    assertCount++;
    assert (reached === 1'b1) else begin
      failCount++;
      $error("[TB] FAIL %s: slot %0d not reached (observed slot %0d)", tag, s, curSlot());
    end
  endtask

  task automatic pulseReset(input int clks);
    reset = 1'b1;
    applyStimulus(1'b0, '0, '0);
    #1;
    resetModel();
    checkOutput();
    for (int i = 0; i < clks; i++) stepClock();
    reset = 1'b0;
  endtask

  initial begin
    int k;
    resetModel();
    applyStimulus(1'b0, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput();
    stepClock();
    reset = 1'b0;

    $display("[TB] idle after reset: underrun every frame, sdata low");
    idle(2 * FRAME + 8);

    $display("[TB] pair A5F0/0F0F then back-to-back pair");
    pulseReset(2);
    offerUntilAccepted(16'hA5F0, 16'h0F0F, 4, "pair1_accept");
    offerUntilAccepted(W'($urandom), W'($urandom), 2 * FRAME, "pair2_accept");

    $display("[TB] valid held high against stalled ready");
    for (int i = 0; i < 3; i++)
      offerUntilAccepted(W'($urandom), W'($urandom), 2 * FRAME, "stall_accept");
    idle(3 * FRAME);

    $display("[TB] accept on an empty load tick");
    k = 0;
    while (!(isFrameStart(t + 1) && !mFull) && (k < 2 * FRAME)) begin
      idle(1);
      k++;
    end
    assertCount++;
    assert ((isFrameStart(t + 1) && !mFull) === 1'b1) else begin
      failCount++;
      $error("[TB] FAIL load_tick_wait: empty load tick not reached (t=%0d)", t);
    end
    applyStimulus(1'b1, W'($urandom), W'($urandom));
    stepClock();
    idle(2 * FRAME + 4);

    $display("[TB] reset asserted at slot 20 with a pair held");
    waitSlot(2, 2 * FRAME, "slot2_wait");
    offerUntilAccepted(W'($urandom), W'($urandom), 4, "pre_reset_accept");
    applyStimulus(1'b0, W'($urandom), W'($urandom));
    waitSlot(20, 2 * FRAME, "slot20_wait");
    pulseReset(3);
    idle(2 * FRAME + 8);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
